// File: rtl/serial_abs_pkg.sv
// Shared types and sizing helpers for the serial absolute-value unit.
// Optional build macro used by this slice: SATURATE_EN (clamp the
// most-negative input to the largest positive value).
package serial_abs_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Number of beats needed to walk the whole operand.
  function automatic int beats(input int width, input int bpc);
    return width / bpc;
  endfunction

  // Beat counter width; never narrower than one bit.
  function automatic int cnt_bits(input int width, input int bpc);
    int n;
    n = width / bpc;
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/abs_slice.sv
// Combinational BPC-bit slice of the "seen-a-one" negation chain:
// bits up to and including the first 1 pass through, later bits invert.
module abs_slice #(
  parameter int BPC = 1
) (
  input  logic [BPC-1:0] bits,
  input  logic           flag_in,
  input  logic           sign,
  output logic [BPC-1:0] bits_out,
  output logic           flag_out
);

  logic chain;

  // Ripple the flag LSB-first through the slice; only negative operands invert.
  always_comb begin
    chain    = flag_in;
    bits_out = '0;
    for (int i = 0; i < BPC; i++) begin
      bits_out[i] = sign ? (bits[i] ^ chain) : bits[i];
      chain       = chain | bits[i];
    end
    flag_out = chain;
  end

endmodule

// File: rtl/serial_abs.sv
// Multi-cycle two's-complement absolute value, BPC bits per clock, with
// valid/ready handshakes on both sides. Build macro: SATURATE_EN.
module serial_abs
  import serial_abs_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BPC   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf
);

  localparam int N  = beats(WIDTH, BPC);
  localparam int CW = cnt_bits(WIDTH, BPC);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t state, state_next;

  logic [WIDTH-1:0]     shreg;
  logic                 sign;
  logic                 flag;
  logic [CW-1:0]        cnt;
  logic [BPC-1:0]       slice_out;
  logic                 slice_flag;
  logic [WIDTH+BPC-1:0] cat;
  logic [WIDTH-1:0]     shifted;
  logic [WIDTH-1:0]     result;
  logic                 last_beat;
  logic                 ovf_next;

  abs_slice #(.BPC(BPC)) u_slice (
    .bits    (shreg[BPC-1:0]),
    .flag_in (flag),
    .sign    (sign),
    .bits_out(slice_out),
    .flag_out(slice_flag)
  );

  // New result bits enter at the MSB end while consumed bits drop off the LSB end.
  assign cat       = {slice_out, shreg};
  assign shifted   = cat[WIDTH+BPC-1:BPC];
  assign last_beat = (cnt == LAST);
  assign ovf_next  = sign & shifted[WIDTH-1];

`ifdef SATURATE_EN
  localparam logic [WIDTH-1:0] SAT_VAL = {1'b0, {(WIDTH-1){1'b1}}};
  assign result = ovf_next ? SAT_VAL : shifted;
`else
  assign result = shifted;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = SHIFT;
      end
      SHIFT: begin
        if (last_beat) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: load on accept, shift one slice per beat, capture result on the last beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg    <= '0;
      sign     <= 1'b0;
      flag     <= 1'b0;
      cnt      <= '0;
      out_data <= '0;
      out_ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            shreg <= in_data;
            sign  <= in_data[WIDTH-1];
            flag  <= 1'b0;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          shreg <= shifted;
          flag  <= slice_flag;
          cnt   <= cnt + 1'b1;
          if (last_beat) begin
            out_data <= result;
            out_ovf  <= ovf_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_abs.sv
// Self-checking bench for serial_abs: an 8-bit/1-bpc instance and a
// 16-bit/4-bpc instance, checked against an arithmetic |x| model.
module tb_serial_abs;

  logic clk;
  logic rst;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_ovf;
  logic [7:0]  a_in_data, a_out_data;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_ovf;
  logic [15:0] b_in_data, b_out_data;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [16:0] qa[$];
  logic [16:0] qb[$];
  int          acc_a[$];

`ifdef SATURATE_EN
  localparam logic [7:0]  LIT80   = 8'h7F;
  localparam logic [15:0] LIT8000 = 16'h7FFF;
`else
  localparam logic [7:0]  LIT80   = 8'h80;
  localparam logic [15:0] LIT8000 = 16'h8000;
`endif

  serial_abs #(.WIDTH(8), .BPC(1)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_ovf(a_out_ovf)
  );

  serial_abs #(.WIDTH(16), .BPC(4)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_ovf(b_out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {ovf, |x|} for a w-bit operand, from plain two's-complement arithmetic.
  function automatic logic [16:0] model_abs(input logic [15:0] x, input int w);
    logic [15:0] mask, minv, xv, r;
    logic        ovf;
    mask = (w == 16) ? 16'hFFFF : ((16'd1 << w) - 16'd1);
    minv = 16'd1 << (w - 1);
    xv   = x & mask;
    if ((xv & minv) != 16'd0) r = (~xv + 16'd1) & mask;
    else                      r = xv;
    ovf = (xv == minv);
`ifdef SATURATE_EN
    if (ovf) r = minv - 16'd1;
`endif
    return {ovf, r};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard maintenance on each rising edge: flush on reset, pop on delivery, push on accept.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      qa.delete();
      qb.delete();
    end else begin
      if (a_out_valid && a_out_ready && qa.size() > 0) void'(qa.pop_front());
      if (a_in_valid && a_in_ready) begin
        qa.push_back(model_abs({8'h00, a_in_data}, 8));
        acc_a.push_back(cyc);
      end
      if (b_out_valid && b_out_ready && qb.size() > 0) void'(qb.pop_front());
      if (b_in_valid && b_in_ready) qb.push_back(model_abs(b_in_data, 16));
    end
  end

  // Compare whatever either DUT presents as valid against the model's oldest entry.
  always @(negedge clk) begin
    if (!rst) begin
      if (a_out_valid) begin
        if (qa.size() == 0) checkOutput("a_unexpected_valid", 32'd1, 32'd0);
        else begin
          checkOutput("a_model_data", {24'h0, a_out_data}, {24'h0, qa[0][7:0]});
          checkOutput("a_model_ovf", {31'h0, a_out_ovf}, {31'h0, qa[0][16]});
        end
      end
      if (b_out_valid) begin
        if (qb.size() == 0) checkOutput("b_unexpected_valid", 32'd1, 32'd0);
        else begin
          checkOutput("b_model_data", {16'h0, b_out_data}, {16'h0, qb[0][15:0]});
          checkOutput("b_model_ovf", {31'h0, b_out_ovf}, {31'h0, qb[0][16]});
        end
      end
    end
  end

  // One operand through the 8-bit unit, with optional consumer stall.
  task automatic applyStimulus(input logic [7:0] d, input logic [7:0] lit, input logic lit_ovf,
                               input int stall);
    int lat;
    @(negedge clk);
    a_in_data   = d;
    a_in_valid  = 1'b1;
    a_out_ready = 1'b0;
    @(negedge clk);
    a_in_valid = 1'b0;
    lat = 0;
    while (!a_out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("a_latency", lat, 32'd8);
    checkOutput("a_data", {24'h0, a_out_data}, {24'h0, lit});
    checkOutput("a_ovf", {31'h0, a_out_ovf}, {31'h0, lit_ovf});
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      checkOutput("a_hold_valid", {31'h0, a_out_valid}, 32'd1);
      checkOutput("a_hold_data", {24'h0, a_out_data}, {24'h0, lit});
    end
    a_out_ready = 1'b1;
    @(negedge clk);
    checkOutput("a_release", {31'h0, a_out_valid}, 32'd0);
    a_out_ready = 1'b0;
  endtask

  // One operand through the 16-bit, 4-bit-per-clock unit.
  task automatic applyStimulusWide(input logic [15:0] d, input logic [15:0] lit, input logic lit_ovf);
    int lat;
    @(negedge clk);
    b_in_data   = d;
    b_in_valid  = 1'b1;
    b_out_ready = 1'b0;
    @(negedge clk);
    b_in_valid = 1'b0;
    lat = 0;
    while (!b_out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("b_latency", lat, 32'd4);
    checkOutput("b_data", {16'h0, b_out_data}, {16'h0, lit});
    checkOutput("b_ovf", {31'h0, b_out_ovf}, {31'h0, lit_ovf});
    b_out_ready = 1'b1;
    @(negedge clk);
    checkOutput("b_release", {31'h0, b_out_valid}, 32'd0);
    b_out_ready = 1'b0;
  endtask

  // Safety net so the run can never hang.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence.
  initial begin
    int k;
    int n0;
    int hits;
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_a_in_ready", {31'h0, a_in_ready}, 32'd1);
    checkOutput("rst_a_out_valid", {31'h0, a_out_valid}, 32'd0);
    checkOutput("rst_a_out_data", {24'h0, a_out_data}, 32'd0);
    checkOutput("rst_a_out_ovf", {31'h0, a_out_ovf}, 32'd0);
    checkOutput("rst_b_in_ready", {31'h0, b_in_ready}, 32'd1);
    checkOutput("rst_b_out_data", {16'h0, b_out_data}, 32'd0);
    rst = 1'b0;

    applyStimulus(8'hFF, 8'h01, 1'b0, 0);
    applyStimulus(8'hD5, 8'h2B, 1'b0, 5);
    applyStimulus(8'h80, LIT80, 1'b1, 0);
    applyStimulus(8'h7F, 8'h7F, 1'b0, 0);
    applyStimulus(8'h81, 8'h7F, 1'b0, 1);

    // Back-to-back 0x00 then 0x76 with the consumer always ready.
    @(negedge clk);
    n0 = acc_a.size();
    a_out_ready = 1'b1;
    a_in_data   = 8'h00;
    a_in_valid  = 1'b1;
    k = 0;
    while (acc_a.size() < n0 + 1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    a_in_data = 8'h76;
    while (acc_a.size() < n0 + 2 && k < 100) begin
      @(negedge clk);
      k++;
    end
    a_in_valid = 1'b0;
    if (acc_a.size() >= n0 + 2)
      checkOutput("a_issue_interval", acc_a[n0+1] - acc_a[n0], 32'd10);
    else
      checkOutput("a_issue_timeout", acc_a.size(), n0 + 2);
    k = 0;
    while (!a_out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    checkOutput("a_b2b_data", {24'h0, a_out_data}, 32'h76);
    @(negedge clk);
    a_out_ready = 1'b0;

    // Reset during the fourth SHIFT beat of 0xFF discards everything.
    @(negedge clk);
    a_in_data  = 8'hFF;
    a_in_valid = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_in_ready", {31'h0, a_in_ready}, 32'd1);
    checkOutput("midrst_out_valid", {31'h0, a_out_valid}, 32'd0);
    checkOutput("midrst_out_data", {24'h0, a_out_data}, 32'd0);
    hits = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (a_out_valid) hits++;
    end
    checkOutput("midrst_no_output", hits, 32'd0);
    applyStimulus(8'h03, 8'h03, 1'b0, 0);

    // Reset and in_valid together: the operand must not be taken.
    @(negedge clk);
    rst        = 1'b1;
    a_in_data  = 8'h85;
    a_in_valid = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    rst        = 1'b0;
    checkOutput("rst_wins_ready", {31'h0, a_in_ready}, 32'd1);
    hits = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (a_out_valid) hits++;
    end
    checkOutput("rst_wins_no_output", hits, 32'd0);

    // Wide configuration.
    applyStimulusWide(16'hFFFE, 16'h0002, 1'b0);
    applyStimulusWide(16'h8000, LIT8000, 1'b1);
    applyStimulusWide(16'h1234, 16'h1234, 1'b0);
    applyStimulusWide(16'h8001, 16'h7FFF, 1'b0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
